// File: rtl/key_pkg.sv
// Shared definitions for the key event controller: FSM encoding and
// default timing constants for a 50 MHz sys_clk.
package key_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_PRESS1 = 3'd1;
   localparam logic [2:0] ST_GAP    = 3'd2;
   localparam logic [2:0] ST_PRESS2 = 3'd3;
   localparam logic [2:0] ST_LONG   = 3'd4;

   localparam logic [19:0] DEB_CNT_DEF    = 20'd50_000;
   localparam logic [25:0] LONG_CNT_DEF   = 26'd50_000_000;
   localparam logic [23:0] DBL_GAP_DEF    = 24'd15_000_000;
   localparam logic [23:0] REPEAT_CNT_DEF = 24'd10_000_000;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/key_level_debounce.sv
// Two-flop synchroniser followed by a level debouncer: key_lvl only follows
// the synced key after it has disagreed for DEB_CNT consecutive cycles.
module key_level_debounce
   import key_pkg::*;
#(
   parameter logic [19:0] DEB_CNT = DEB_CNT_DEF
) (
   input  logic sys_clk,
   input  logic sys_rstn,
   input  logic key_in,
   output logic key_lvl
);

   logic        sync1;
   logic        sync2;
   logic [19:0] cnt;

   always_ff @(posedge sys_clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         cnt     <= '0;
         key_lvl <= 1'b0;
      end else begin
         sync1 <= key_in;
         sync2 <= sync1;
         if (sync2 == key_lvl) begin
            cnt <= '0;
         end else if (cnt == DEB_CNT - 20'd1) begin
            key_lvl <= ~key_lvl;
            cnt     <= '0;
         end else begin
            cnt <= cnt + 20'd1;
         end
      end
   end

endmodule

// File: rtl/key_event_ctrl.sv
// Key press classifier: debounced level feeds an edge detector and a
// five-state FSM that emits one-cycle short/double/long/repeat pulses.
//
//  state     | meaning
//  ----------+---------------------------------------------------
//  ST_IDLE   | waiting for a press
//  ST_PRESS1 | first press held, timing towards long
//  ST_GAP    | released after first press, waiting for a second
//  ST_PRESS2 | second press held, double fires on release
//  ST_LONG   | long hold reached, periodic repeat ticks
module key_event_ctrl
   import key_pkg::*;
#(
   parameter logic [19:0] DEB_CNT    = DEB_CNT_DEF,
   parameter logic [25:0] LONG_CNT   = LONG_CNT_DEF,
   parameter logic [23:0] DBL_GAP    = DBL_GAP_DEF,
   parameter logic [23:0] REPEAT_CNT = REPEAT_CNT_DEF
) (
   input  logic sys_clk,
   input  logic sys_rstn,
   input  logic key_in,
   input  logic en,
   input  logic repeat_en,
   output logic short_pulse,
   output logic double_pulse,
   output logic long_pulse,
   output logic repeat_pulse,
   output logic key_lvl,
   output logic busy
);

   localparam int unsigned TMR_MAX = max3(LONG_CNT, DBL_GAP, REPEAT_CNT);
   localparam int          TW      = $clog2(TMR_MAX + 1);

   localparam logic [TW-1:0] LONG_T = TW'(LONG_CNT - 26'd1);
   localparam logic [TW-1:0] GAP_T  = TW'(DBL_GAP - 24'd1);
   localparam logic [TW-1:0] REP_T  = TW'(REPEAT_CNT - 24'd1);
   localparam logic [TW-1:0] TMR_SAT = TW'(TMR_MAX);

   logic          lvl_q;
   logic          rise;
   logic          fall;
   logic [2:0]    state;
   logic [2:0]    state_nxt;
   logic [TW-1:0] timer;
   logic          rep_clr;
   logic          short_nxt;
   logic          double_nxt;
   logic          long_nxt;
   logic          repeat_nxt;

   key_level_debounce #(.DEB_CNT(DEB_CNT)) u_deb (
      .sys_clk  (sys_clk),
      .sys_rstn (sys_rstn),
      .key_in   (key_in),
      .key_lvl  (key_lvl)
   );

   assign rise = key_lvl & ~lvl_q;
   assign fall = ~key_lvl & lvl_q;

   // Edges take priority over a coincident timeout in every state.
   always_comb begin
      state_nxt  = state;
      rep_clr    = 1'b0;
      short_nxt  = 1'b0;
      double_nxt = 1'b0;
      long_nxt   = 1'b0;
      repeat_nxt = 1'b0;
      if (!en) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (rise) state_nxt = ST_PRESS1;
            end
            ST_PRESS1: begin
               if (fall) begin
                  state_nxt = ST_GAP;
               end else if (timer == LONG_T) begin
                  long_nxt  = 1'b1;
                  state_nxt = ST_LONG;
               end
            end
            ST_GAP: begin
               if (rise) begin
                  state_nxt = ST_PRESS2;
               end else if (timer == GAP_T) begin
                  short_nxt = 1'b1;
                  state_nxt = ST_IDLE;
               end
            end
            ST_PRESS2: begin
               if (fall) begin
                  double_nxt = 1'b1;
                  state_nxt  = ST_IDLE;
               end
            end
            ST_LONG: begin
               if (fall) begin
                  state_nxt = ST_IDLE;
               end else if (timer == REP_T) begin
                  rep_clr    = 1'b1;
                  repeat_nxt = repeat_en;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         lvl_q        <= 1'b0;
         state        <= ST_IDLE;
         busy         <= 1'b0;
         timer        <= '0;
         short_pulse  <= 1'b0;
         double_pulse <= 1'b0;
         long_pulse   <= 1'b0;
         repeat_pulse <= 1'b0;
      end else begin
         lvl_q        <= key_lvl;
         state        <= state_nxt;
         busy         <= (state_nxt != ST_IDLE);
         short_pulse  <= short_nxt;
         double_pulse <= double_nxt;
         long_pulse   <= long_nxt;
         repeat_pulse <= repeat_nxt;
         if (!en || (state_nxt != state) || rep_clr) begin
            timer <= '0;
         end else if (timer != TMR_SAT) begin
            timer <= timer + 1'b1;
         end
      end
   end

endmodule
